// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: data/address widths, stall constants,
// operation codes (op_i) and result-class codes (sel_i).
// The MUL class carries MULT/MULTU and the multi-cycle DIV/DIVU.
package ex_stage_pkg;

  localparam int unsigned DataWidth  = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [7:0] {
    OpNop   = 8'h00,
    OpSrl   = 8'h02,
    OpSra   = 8'h03,
    OpMfhi  = 8'h10,
    OpMthi  = 8'h11,
    OpMflo  = 8'h12,
    OpMtlo  = 8'h13,
    OpMult  = 8'h18,
    OpMultu = 8'h19,
    OpDiv   = 8'h1a,
    OpDivu  = 8'h1b,
    OpAdd   = 8'h20,
    OpAddu  = 8'h21,
    OpSub   = 8'h22,
    OpSubu  = 8'h23,
    OpAnd   = 8'h24,
    OpOr    = 8'h25,
    OpXor   = 8'h26,
    OpNor   = 8'h27,
    OpSlt   = 8'h2a,
    OpSltu  = 8'h2b,
    OpSll   = 8'h7c
  } op_e;

  typedef enum logic [2:0] {
    SelNop        = 3'd0,
    SelLogic      = 3'd1,
    SelShift      = 3'd2,
    SelMove       = 3'd3,
    SelArith      = 3'd4,
    SelMul        = 3'd5,
    SelJumpBranch = 3'd6
  } sel_e;

  // Two's-complement negate when neg is set.
  function automatic logic [DataWidth-1:0] neg_if(input logic [DataWidth-1:0] v,
                                                  input logic                 neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle.
//   start      : divide op present (sampled only in idle)
//   signed_div : treat op1/op2 as signed (DIV) rather than unsigned (DIVU)
//   op1, op2   : dividend, divisor
//   result     : {remainder, quotient}, valid while ready
//   ready      : high for the single done cycle
// A zero divisor skips straight to done with an all-zero result.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   signed_div,
  input  logic [DataWidth-1:0]   op1,
  input  logic [DataWidth-1:0]   op2,
  output logic [2*DataWidth-1:0] result,
  output logic                   ready
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                 state_q;
  logic [4:0]             cnt_q;
  logic [DataWidth-1:0]   quo_q, rem_q, dvs_q;
  logic                   neg_quo_q, neg_rem_q;
  logic [2*DataWidth-1:0] result_q;

  logic [DataWidth:0]     partial, diff;
  logic                   fits;
  logic [DataWidth-1:0]   quo_nxt, rem_nxt;

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    partial = {rem_q, quo_q[DataWidth-1]};
    diff    = partial - {1'b0, dvs_q};
    fits    = ~diff[DataWidth];
    rem_nxt = fits ? diff[DataWidth-1:0] : partial[DataWidth-1:0];
    quo_nxt = {quo_q[DataWidth-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            // Signed division runs on magnitudes; signs are restored at the end.
            neg_quo_q <= signed_div & (op1[DataWidth-1] ^ op2[DataWidth-1]);
            neg_rem_q <= signed_div & op1[DataWidth-1];
            quo_q     <= neg_if(op1, signed_div & op1[DataWidth-1]);
            dvs_q     <= neg_if(op2, signed_div & op2[DataWidth-1]);
            rem_q     <= '0;
            cnt_q     <= '0;
            if (op2 == '0) begin
              result_q <= '0;
              state_q  <= StDone;
            end else begin
              state_q  <= StBusy;
            end
          end
        end
        StBusy: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= {neg_if(rem_nxt, neg_rem_q), neg_if(quo_nxt, neg_quo_q)};
            state_q  <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result = result_q;
  assign ready  = (state_q == StDone);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/shift/move/multiply plus a multi-cycle divider.
// Inputs : op_i/sel_i (operation and result class), num1_i/num2_i (operands),
//          desReg_addr_i/en_wd_i (destination), link_address_i, hi_i/lo_i,
//          this_ins_in_delayslot_i and rom_ins_i (carried for later stages, unused here).
// Outputs: wd_o/waddr_o/wdata_o (GPR write), whilo_o/hi_o/lo_o (HI/LO write),
//          stop_req_o (stall request while a division is in flight).
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            op_i,
  input  logic [2:0]            sel_i,
  input  logic [DataWidth-1:0]  num1_i,
  input  logic [DataWidth-1:0]  num2_i,
  input  logic [RegAddrBus-1:0] desReg_addr_i,
  input  logic                  en_wd_i,
  input  logic                  this_ins_in_delayslot_i,
  input  logic [DataWidth-1:0]  link_address_i,
  input  logic [DataWidth-1:0]  rom_ins_i,
  input  logic [DataWidth-1:0]  hi_i,
  input  logic [DataWidth-1:0]  lo_i,
  output logic                  wd_o,
  output logic [RegAddrBus-1:0] waddr_o,
  output logic [DataWidth-1:0]  wdata_o,
  output logic                  whilo_o,
  output logic [DataWidth-1:0]  hi_o,
  output logic [DataWidth-1:0]  lo_o,
  output logic                  stop_req_o
);

  op_e  op;
  sel_e sel;
  assign op  = op_e'(op_i);
  assign sel = sel_e'(sel_i);

  logic                   unused_inputs;
  assign unused_inputs = ^{this_ins_in_delayslot_i, rom_ins_i};

  logic [DataWidth-1:0]   add_res, sub_res;
  logic                   add_ovf, sub_ovf;
  logic [2*DataWidth-1:0] prod_s, prod_u;

  assign add_res = num1_i + num2_i;
  assign sub_res = num1_i - num2_i;
  assign add_ovf = (num1_i[31] == num2_i[31]) & (add_res[31] != num1_i[31]);
  assign sub_ovf = (num1_i[31] != num2_i[31]) & (sub_res[31] != num1_i[31]);
  assign prod_s  = $signed({{32{num1_i[31]}}, num1_i}) * $signed({{32{num2_i[31]}}, num2_i});
  assign prod_u  = {32'd0, num1_i} * {32'd0, num2_i};

  logic                   is_div, div_signed, div_ready;
  logic [2*DataWidth-1:0] div_result;

  assign is_div     = (sel == SelMul) & ((op == OpDiv) | (op == OpDivu));
  assign div_signed = (op == OpDiv);

  div_unit u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (is_div),
    .signed_div (div_signed),
    .op1        (num1_i),
    .op2        (num2_i),
    .result     (div_result),
    .ready      (div_ready)
  );

  logic valid;
  assign valid = en_wd_i & (sel != SelNop);

  always_comb begin
    wd_o       = 1'b0;
    waddr_o    = '0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stop_req_o = NoStop;
    if (rst_n) begin
      waddr_o = desReg_addr_i;
      case (sel)
        SelLogic: begin
          wd_o = valid;
          case (op)
            OpAnd:   wdata_o = num1_i & num2_i;
            OpOr:    wdata_o = num1_i | num2_i;
            OpXor:   wdata_o = num1_i ^ num2_i;
            OpNor:   wdata_o = ~(num1_i | num2_i);
            default: wd_o    = 1'b0;
          endcase
        end
        SelShift: begin
          wd_o = valid;
          case (op)
            OpSll:   wdata_o = num2_i << num1_i[4:0];
            OpSrl:   wdata_o = num2_i >> num1_i[4:0];
            OpSra:   wdata_o = $unsigned($signed(num2_i) >>> num1_i[4:0]);
            default: wd_o    = 1'b0;
          endcase
        end
        SelMove: begin
          case (op)
            OpMfhi: begin wd_o = valid; wdata_o = hi_i; end
            OpMflo: begin wd_o = valid; wdata_o = lo_i; end
            OpMthi: begin whilo_o = valid; hi_o = num1_i; lo_o = lo_i;   end
            OpMtlo: begin whilo_o = valid; hi_o = hi_i;   lo_o = num1_i; end
            default: ;
          endcase
        end
        SelArith: begin
          wd_o = valid;
          case (op)
            OpAdd:   begin wdata_o = add_res; wd_o = valid & ~add_ovf; end
            OpAddu:  wdata_o = add_res;
            OpSub:   begin wdata_o = sub_res; wd_o = valid & ~sub_ovf; end
            OpSubu:  wdata_o = sub_res;
            OpSlt:   wdata_o = {31'd0, $signed(num1_i) < $signed(num2_i)};
            OpSltu:  wdata_o = {31'd0, num1_i < num2_i};
            default: wd_o    = 1'b0;
          endcase
        end
        SelMul: begin
          case (op)
            OpMult:  begin whilo_o = valid; {hi_o, lo_o} = prod_s; end
            OpMultu: begin whilo_o = valid; {hi_o, lo_o} = prod_u; end
            OpDiv, OpDivu: begin
              // Stall until the divider's done cycle, then write HI/LO once.
              stop_req_o = div_ready ? NoStop : Stop;
              if (div_ready) begin
                whilo_o      = valid;
                {hi_o, lo_o} = div_result;
              end
            end
            default: ;
          endcase
        end
        SelJumpBranch: begin
          wd_o    = valid;
          wdata_o = link_address_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  op_i;
  logic [2:0]  sel_i;
  logic [31:0] num1_i, num2_i, link_address_i, rom_ins_i, hi_i, lo_i;
  logic [4:0]  desReg_addr_i;
  logic        en_wd_i, this_ins_in_delayslot_i;
  logic        wd_o, whilo_o, stop_req_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .op_i                    (op_i),
    .sel_i                   (sel_i),
    .num1_i                  (num1_i),
    .num2_i                  (num2_i),
    .desReg_addr_i           (desReg_addr_i),
    .en_wd_i                 (en_wd_i),
    .this_ins_in_delayslot_i (this_ins_in_delayslot_i),
    .link_address_i          (link_address_i),
    .rom_ins_i               (rom_ins_i),
    .hi_i                    (hi_i),
    .lo_i                    (lo_i),
    .wd_o                    (wd_o),
    .waddr_o                 (waddr_o),
    .wdata_o                 (wdata_o),
    .whilo_o                 (whilo_o),
    .hi_o                    (hi_o),
    .lo_o                    (lo_o),
    .stop_req_o              (stop_req_o)
  );

  localparam int FWd = 0, FWaddr = 1, FWdata = 2, FWhilo = 3, FHi = 4, FLo = 5, FStop = 6;

  typedef struct {
    string       tag;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int fld);
    case (fld)
      FWd:     return {31'd0, wd_o};
      FWaddr:  return {27'd0, waddr_o};
      FWdata:  return wdata_o;
      FWhilo:  return {31'd0, whilo_o};
      FHi:     return hi_o;
      FLo:     return lo_o;
      default: return {31'd0, stop_req_o};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int fld, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.fld = fld; e.val = val;
    sb.push_back(e);
  endtask

  // Outputs are compared on the falling edge, half a cycle away from state updates.
  task automatic drain();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.fld), e.val);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    op_i = op; sel_i = sel; num1_i = a; num2_i = b;
  endtask

  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    issue(sgn ? OpDiv : OpDivu, SelMul, a, b);
    expect_val({tag, ".stop_c0"}, FStop, 32'd1);
    expect_val({tag, ".whilo_c0"}, FWhilo, 32'd0);
    drain();
    if (b != 32'd0) begin
      for (int c = 1; c <= 32; c++) begin
        @(posedge clk);
        expect_val($sformatf("%s.stop_c%0d", tag, c), FStop, 32'd1);
        expect_val($sformatf("%s.whilo_c%0d", tag, c), FWhilo, 32'd0);
        drain();
      end
    end
    @(posedge clk);
    expect_val({tag, ".stop_done"}, FStop, 32'd0);
    expect_val({tag, ".whilo_done"}, FWhilo, 32'd1);
    expect_val({tag, ".lo"}, FLo, exp_lo);
    expect_val({tag, ".hi"}, FHi, exp_hi);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          sa, sb_;
    int unsigned ua, ub;

    rst_n = 1'b0; op_i = OpAddu; sel_i = SelArith; num1_i = 32'h7fff_ffff; num2_i = 32'd1;
    desReg_addr_i = 5'd9; en_wd_i = 1'b1; this_ins_in_delayslot_i = 1'b0;
    link_address_i = 32'h0040_0008; rom_ins_i = 32'h0; hi_i = 32'hdead_beef;
    lo_i = 32'hcafe_f00d;

    // Reset: every output held at zero.
    expect_val("rst.wd", FWd, 0);       expect_val("rst.waddr", FWaddr, 0);
    expect_val("rst.wdata", FWdata, 0); expect_val("rst.whilo", FWhilo, 0);
    expect_val("rst.hi", FHi, 0);       expect_val("rst.lo", FLo, 0);
    expect_val("rst.stop", FStop, 0);
    drain();
    @(posedge clk); #1 rst_n = 1'b1;

    issue(OpAdd, SelArith, 32'h7fff_ffff, 32'd1);
    expect_val("add_ovf.wd", FWd, 0); drain();
    issue(OpAddu, SelArith, 32'h7fff_ffff, 32'd1);
    expect_val("addu.wd", FWd, 1); expect_val("addu.wdata", FWdata, 32'h8000_0000);
    expect_val("addu.waddr", FWaddr, 9); drain();
    issue(OpSub, SelArith, 32'h8000_0000, 32'd1);
    expect_val("sub_ovf.wd", FWd, 0); drain();
    issue(OpSubu, SelArith, 32'h8000_0000, 32'd1);
    expect_val("subu.wdata", FWdata, 32'h7fff_ffff); drain();
    issue(OpSlt, SelArith, 32'hffff_ffff, 32'd1);
    expect_val("slt.wdata", FWdata, 1); drain();
    issue(OpSltu, SelArith, 32'hffff_ffff, 32'd1);
    expect_val("sltu.wdata", FWdata, 0); drain();

    issue(OpAnd, SelLogic, 32'hf0f0_1234, 32'h0ff0_ff00);
    expect_val("and", FWdata, 32'h00f0_1200); drain();
    issue(OpOr, SelLogic, 32'hf0f0_1234, 32'h0ff0_ff00);
    expect_val("or", FWdata, 32'hfff0_ff34); drain();
    issue(OpXor, SelLogic, 32'hf0f0_1234, 32'h0ff0_ff00);
    expect_val("xor", FWdata, 32'hff00_ed34); drain();
    issue(OpNor, SelLogic, 32'hf0f0_1234, 32'h0ff0_ff00);
    expect_val("nor", FWdata, 32'h000f_00cb); drain();

    issue(OpSll, SelShift, 32'd4, 32'h1234_5678);
    expect_val("sll", FWdata, 32'h2345_6780); drain();
    issue(OpSrl, SelShift, 32'd4, 32'h8000_0010);
    expect_val("srl", FWdata, 32'h0800_0001); drain();
    issue(OpSra, SelShift, 32'd4, 32'h8000_0010);
    expect_val("sra", FWdata, 32'hf800_0001); drain();

    issue(OpMfhi, SelMove, 32'd0, 32'd0);
    expect_val("mfhi.wdata", FWdata, 32'hdead_beef); expect_val("mfhi.wd", FWd, 1); drain();
    issue(OpMtlo, SelMove, 32'h1234_5678, 32'd0);
    expect_val("mtlo.whilo", FWhilo, 1); expect_val("mtlo.lo", FLo, 32'h1234_5678);
    expect_val("mtlo.hi", FHi, 32'hdead_beef); drain();

    issue(OpMult, SelMul, 32'hffff_fffe, 32'd3);
    expect_val("mult.hi", FHi, 32'hffff_ffff); expect_val("mult.lo", FLo, 32'hffff_fffa);
    expect_val("mult.whilo", FWhilo, 1); expect_val("mult.stop", FStop, 0); drain();
    issue(OpMultu, SelMul, 32'hffff_fffe, 32'd3);
    expect_val("multu.hi", FHi, 32'h0000_0002); expect_val("multu.lo", FLo, 32'hffff_fffa);
    drain();

    issue(OpNop, SelJumpBranch, 32'd0, 32'd0);
    expect_val("jal.wdata", FWdata, 32'h0040_0008); expect_val("jal.wd", FWd, 1); drain();
    issue(OpNop, SelNop, 32'd5, 32'd6);
    expect_val("nop.wd", FWd, 0); expect_val("nop.whilo", FWhilo, 0); drain();
    en_wd_i = 1'b0;
    issue(OpMult, SelMul, 32'd5, 32'd6);
    expect_val("noen.whilo", FWhilo, 0); drain();
    issue(OpAddu, SelArith, 32'd5, 32'd6);
    expect_val("noen.wd", FWd, 0); drain();
    en_wd_i = 1'b1;

    run_div("div_m7_2", 1'b1, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 32'hffff_ffff);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0);

    // Reset lands while the divider is at iteration 10 of a long division.
    issue(OpDivu, SelMul, 32'd1000, 32'd3);
    expect_val("rstmid.stop_c0", FStop, 1); drain();
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0; op_i = OpNop; sel_i = SelNop;
    expect_val("rstmid.stop_in_rst", FStop, 0); expect_val("rstmid.lo_in_rst", FLo, 0);
    drain();
    @(posedge clk); #1 rst_n = 1'b1;
    expect_val("rstmid.stop_after", FStop, 0); drain();
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    // Back-to-back: the second division must start fresh from idle.
    run_div("divu_9_2", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1);
    run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);

    for (int i = 0; i < 2; i++) begin
      sa  = int'($urandom_range(1, 32'h7fff_ffff));
      sb_ = int'($urandom_range(1, 50000));
      if (i == 0) sa = -sa; else sb_ = -sb_;
      run_div($sformatf("div_rand%0d", i), 1'b1, sa, sb_, sa / sb_, sa % sb_);
    end
    ua = $urandom; ub = $urandom_range(1, 32'hffff);
    run_div("divu_rand", 1'b0, ua, ub, ua / ub, ua % ub);

    issue(OpNop, SelNop, 32'd0, 32'd0);
    expect_val("idle.stop", FStop, 0); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
